credit_control: RTL and testbench
=================================

Name: credit_control

Overview:
- Credit counter that consumes a CreditInterfaceInput and produces a CreditInterfaceOutput, both from CREDIT_PKG.
- Sits between the PSL command/response path and the command arbiter.
- Loads the PSL room on job start, debits one credit per issued command and returns credits on each response.
- The arbiter only issues a command while credits are available.

Parameters:
MAX_CREDITS, CREDITS_TOTAL (64), ceiling for the credit count; room above this is clamped.
LOW_WATER, 8'h02, threshold at or below which credit_low asserts.

Ports:
clock  input  1  core clock.
rstn  input  1  asynchronous active-low reset.
enabled_in  input  1  job enable; rising starts a load, low forces IDLE.
credit_in  input  CreditInterfaceInput (19b)  valid_request, valid_response, response_credits[0:8], room[0:7].
credit_out  output  CreditInterfaceOutput (8b)  current credit count.
credit_available  output  1  RUN and credits != 0.
credit_low  output  1  RUN and credits <= LOW_WATER.
credit_error  output  2  sticky error bits: [0] underflow/protocol, [1] overflow.

Behaviour:
- Reset (rstn low, async):
  - credits = 0, state = IDLE, credit_available = 0, credit_low = 0, credit_error = 2'b00.
  - All outputs are registered.
- States: IDLE, LOAD, RUN.
- IDLE:
  - Credits are held at 0.
  - enabled_in = 1 -> LOAD next cycle.
- LOAD (exactly one cycle):
  - credits <= min(room, MAX_CREDITS); credit_error cleared.
  - Next state is RUN.
  - valid_request or valid_response in IDLE or LOAD is ignored and sets credit_error[0].
- RUN:
  - Each cycle: sum = credits - valid_request + (valid_response ? sign-extended response_credits : 0).
  - sum is evaluated in 11-bit signed arithmetic.
  - response_credits is 9-bit two's complement, range -256..+255; negative values withdraw credits.
  - sum < 0 -> credits <= 0, set credit_error[0].
  - sum > MAX_CREDITS -> credits <= MAX_CREDITS, set credit_error[1].
  - Otherwise credits <= sum[7:0].
- Simultaneous request and response in one cycle: both are applied in the same update; net zero leaves credits unchanged.
- valid_request while credits == 0: counts as underflow; credits stay 0; credit_error[0] set.
- Latency: credit_out, credit_available and credit_low all reflect an event one cycle after it is sampled. No combinational path from credit_in to any output.
- enabled_in deasserted (any state): next cycle state = IDLE, credits = 0, flags = 0. credit_error is retained until the next LOAD.
- enabled_in held high in RUN: stays in RUN. A re-load requires enabled_in low for at least one cycle.
- Mid-operation rstn assertion: immediate return to reset values. No credit is carried across reset.
- credit_error bits are sticky; they are cleared only by reset or by entering LOAD.

Test Plan:
1. Reset then enabled_in=1 with room=0x20 -> IDLE, LOAD, RUN; credit_out=0x20, credit_available=1, credit_low=0 three cycles after enable.
2. room=0x50, MAX_CREDITS=64 -> credit_out=0x40 after load; credit_error=00 (clamp on load is not an error).
3. From 0x20: 3 requests back-to-back, then request plus response(+1) in the same cycle, then response(+4) -> 0x1F, 0x1E, 0x1D, 0x1D, 0x21; each value appears one cycle after its event.
4. From 0x03: response_credits=9'h1FE (-2) -> 0x01 with credit_low=1; two more requests -> 0x00 with credit_available=0, then credit_error[0]=1, credit_out stays 0x00.
5. From 0x3F: response(+5) -> credit_out=0x40, credit_error[1]=1; error persists until enabled_in toggles low/high, then LOAD clears it.
6. enabled_in dropped mid-RUN at 0x12 -> next cycle credit_out=0, credit_available=0. A request in IDLE sets credit_error[0]. rstn pulse mid-RUN asynchronously zeroes all outputs.

Source files
------------

// File: rtl/credit_control.sv
// Credit counter between the PSL command/response path and the command arbiter:
// loads PSL room on job start, debits per issued command, refunds per response.
package credit_pkg;

  typedef struct packed {
    logic       valid_request;
    logic       valid_response;
    logic [8:0] response_credits;
    logic [7:0] room;
  } credit_interface_input_t;

  typedef struct packed {
    logic [7:0] credits;
  } credit_interface_output_t;

endpackage

module credit_control
  import credit_pkg::*;
#(
  parameter int         MAX_CREDITS = 64,
  parameter logic [7:0] LOW_WATER   = 8'h02
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     enabled_in,
  input  credit_interface_input_t  credit_in,
  output credit_interface_output_t credit_out,
  output logic                     credit_available,
  output logic                     credit_low,
  output logic [1:0]               credit_error,
  output logic [1:0]               state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [7:0]        MAX_C8  = MAX_CREDITS[7:0];
  localparam logic signed [10:0] MAX_S11 = MAX_CREDITS[10:0];

  logic [1:0] state_q, state_d;
  logic [7:0] credits_q, credits_d;
  logic       avail_q, avail_d;
  logic       low_q, low_d;
  logic [1:0] error_q, error_d;

  // valid_request / valid_response are single-cycle pulses with no back-pressure:
  // every cycle either flag is high counts as one event, there is no ready.
  logic              any_valid;
  logic [7:0]        load_room;
  logic signed [10:0] credits_ext;
  logic signed [10:0] req_ext;
  logic signed [10:0] resp_ext;
  logic signed [10:0] sum;

  always_comb begin
    any_valid   = credit_in.valid_request | credit_in.valid_response;
    load_room   = (credit_in.room > MAX_C8) ? MAX_C8 : credit_in.room;
    credits_ext = {3'b000, credits_q};
    req_ext     = {10'd0, credit_in.valid_request};
    resp_ext    = credit_in.valid_response
                  ? {{2{credit_in.response_credits[8]}}, credit_in.response_credits}
                  : 11'sd0;
    sum         = credits_ext - req_ext + resp_ext;
  end

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    error_d   = error_q;

    case (state_q)
      ST_IDLE: begin
        credits_d = 8'd0;
        if (any_valid) error_d[0] = 1'b1;
        if (enabled_in) begin
          state_d = ST_LOAD;
          // Entering LOAD wipes old errors; a stray event this cycle is still flagged.
          error_d = {1'b0, any_valid};
        end
      end

      ST_LOAD: begin
        if (any_valid) error_d[0] = 1'b1;
        if (enabled_in) begin
          state_d   = ST_RUN;
          credits_d = load_room;
        end else begin
          state_d   = ST_IDLE;
          credits_d = 8'd0;
        end
      end

      ST_RUN: begin
        if (!enabled_in) begin
          state_d   = ST_IDLE;
          credits_d = 8'd0;
        end else if (sum < 11'sd0) begin
          credits_d  = 8'd0;
          error_d[0] = 1'b1;
        end else if (sum > MAX_S11) begin
          credits_d  = MAX_C8;
          error_d[1] = 1'b1;
        end else begin
          credits_d = sum[7:0];
        end
      end

      default: begin
        state_d   = ST_IDLE;
        credits_d = 8'd0;
      end
    endcase
  end

  // Flags are computed from next-state values so they line up with credit_out.
  always_comb begin
    avail_d = (state_d == ST_RUN) && (credits_d != 8'd0);
    low_d   = (state_d == ST_RUN) && (credits_d <= LOW_WATER);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      credits_q <= 8'd0;
      avail_q   <= 1'b0;
      low_q     <= 1'b0;
      error_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      avail_q   <= avail_d;
      low_q     <= low_d;
      error_q   <= error_d;
    end
  end

  assign credit_out.credits = credits_q;
  assign credit_available   = avail_q;
  assign credit_low         = low_q;
  assign credit_error       = error_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_credit_control.sv
// Directed bench for credit_control: load, clamp, debit/refund, under/overflow,
// disable and asynchronous reset behaviour.
module tb_credit_control;
  import credit_pkg::*;

  logic                     clock;
  logic                     rstn;
  logic                     enabled_in;
  credit_interface_input_t  credit_in;
  credit_interface_output_t credit_out;
  logic                     credit_available;
  logic                     credit_low;
  logic [1:0]               credit_error;
  logic [1:0]               state_dbg;

  int checks;
  int failures;

  credit_control #(.MAX_CREDITS(64), .LOW_WATER(8'h02)) dut (
    .clock            (clock),
    .rstn             (rstn),
    .enabled_in       (enabled_in),
    .credit_in        (credit_in),
    .credit_out       (credit_out),
    .credit_available (credit_available),
    .credit_low       (credit_low),
    .credit_error     (credit_error),
    .state_dbg        (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    credit_in = '0;
  endtask

  task automatic drive(input logic req, input logic resp, input logic [8:0] rc);
    credit_in.valid_request    = req;
    credit_in.valid_response   = resp;
    credit_in.response_credits = rc;
  endtask

  // Drop enable for a cycle, then enable with the given room; ends in RUN.
  task automatic start_job(input logic [7:0] room);
    idle_inputs();
    enabled_in = 1'b0;
    tick();
    credit_in.room = room;
    enabled_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    enabled_in = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (credit_out.credits !== 8'h00 || credit_available !== 1'b0 || credit_low !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b/%b exp=00/0/0", credit_out.credits, credit_available, credit_low);
    end
    checks++;
    if (credit_error !== 2'b00 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_err_state got=%b/%0d exp=00/0", credit_error, state_dbg);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_load_basic();
    idle_inputs();
    enabled_in = 1'b0;
    tick();
    credit_in.room = 8'h20;
    enabled_in = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 2'd1 || credit_out.credits !== 8'h00) begin
      failures++;
      $display("FAIL load_state got=%0d/%h exp=1/00", state_dbg, credit_out.credits);
    end
    tick();
    checks++;
    if (state_dbg !== 2'd2 || credit_out.credits !== 8'h20) begin
      failures++;
      $display("FAIL run_entry got=%0d/%h exp=2/20", state_dbg, credit_out.credits);
    end
    tick();
    checks++;
    if (credit_out.credits !== 8'h20 || credit_available !== 1'b1 || credit_low !== 1'b0) begin
      failures++;
      $display("FAIL load_flags got=%h/%b/%b exp=20/1/0", credit_out.credits, credit_available, credit_low);
    end
  endtask

  task automatic test_clamp();
    start_job(8'h50);
    checks++;
    if (credit_out.credits !== 8'h40 || credit_error !== 2'b00) begin
      failures++;
      $display("FAIL clamp_load got=%h/%b exp=40/00", credit_out.credits, credit_error);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_vals [0:4];
    exp_vals[0] = 8'h1F; exp_vals[1] = 8'h1E; exp_vals[2] = 8'h1D;
    exp_vals[3] = 8'h1D; exp_vals[4] = 8'h21;
    start_job(8'h20);
    for (int i = 0; i < 5; i++) begin
      if (i < 3)       drive(1'b1, 1'b0, 9'h000);
      else if (i == 3) drive(1'b1, 1'b1, 9'h001);
      else             drive(1'b0, 1'b1, 9'h004);
      checks++;
      if (i > 0 && credit_out.credits !== exp_vals[i-1]) begin
        failures++;
        $display("FAIL b2b_hold%0d got=%h exp=%h", i, credit_out.credits, exp_vals[i-1]);
      end
      tick();
      checks++;
      if (credit_out.credits !== exp_vals[i]) begin
        failures++;
        $display("FAIL b2b_step%0d got=%h exp=%h", i, credit_out.credits, exp_vals[i]);
      end
    end
    idle_inputs();
    credit_in.room = 8'h20;
    tick();
    checks++;
    if (credit_out.credits !== 8'h21 || credit_error !== 2'b00) begin
      failures++;
      $display("FAIL b2b_idle got=%h/%b exp=21/00", credit_out.credits, credit_error);
    end
  endtask

  task automatic test_underflow();
    start_job(8'h03);
    checks++;
    if (credit_low !== 1'b0 || credit_available !== 1'b1) begin
      failures++;
      $display("FAIL low_boundary3 got=%b/%b exp=0/1", credit_low, credit_available);
    end
    drive(1'b0, 1'b1, 9'h1FE);
    tick();
    checks++;
    if (credit_out.credits !== 8'h01 || credit_low !== 1'b1 || credit_available !== 1'b1) begin
      failures++;
      $display("FAIL neg_resp got=%h/%b/%b exp=01/1/1", credit_out.credits, credit_low, credit_available);
    end
    drive(1'b1, 1'b0, 9'h000);
    tick();
    checks++;
    if (credit_out.credits !== 8'h00 || credit_available !== 1'b0 || credit_error !== 2'b00) begin
      failures++;
      $display("FAIL to_zero got=%h/%b/%b exp=00/0/00", credit_out.credits, credit_available, credit_error);
    end
    tick();
    checks++;
    if (credit_out.credits !== 8'h00 || credit_error !== 2'b01 || credit_low !== 1'b1) begin
      failures++;
      $display("FAIL underflow got=%h/%b/%b exp=00/01/1", credit_out.credits, credit_error, credit_low);
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    start_job(8'h3F);
    checks++;
    if (credit_out.credits !== 8'h3F || credit_error !== 2'b00) begin
      failures++;
      $display("FAIL reload_clears got=%h/%b exp=3f/00", credit_out.credits, credit_error);
    end
    drive(1'b0, 1'b1, 9'h005);
    tick();
    checks++;
    if (credit_out.credits !== 8'h40 || credit_error !== 2'b10) begin
      failures++;
      $display("FAIL overflow got=%h/%b exp=40/10", credit_out.credits, credit_error);
    end
    idle_inputs();
    tick();
    checks++;
    if (credit_error !== 2'b10 || credit_out.credits !== 8'h40) begin
      failures++;
      $display("FAIL overflow_sticky got=%h/%b exp=40/10", credit_out.credits, credit_error);
    end
    enabled_in = 1'b0;
    tick();
    checks++;
    if (credit_error !== 2'b10 || credit_out.credits !== 8'h00 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL disable_keeps_err got=%h/%b/%0d exp=00/10/0", credit_out.credits, credit_error, state_dbg);
    end
    enabled_in = 1'b1;
    tick();
    checks++;
    if (credit_error !== 2'b00 || state_dbg !== 2'd1) begin
      failures++;
      $display("FAIL load_clears_err got=%b/%0d exp=00/1", credit_error, state_dbg);
    end
    tick();
  endtask

  task automatic test_disable_and_reset();
    start_job(8'h12);
    checks++;
    if (credit_out.credits !== 8'h12) begin
      failures++;
      $display("FAIL start12 got=%h exp=12", credit_out.credits);
    end
    enabled_in = 1'b0;
    tick();
    checks++;
    if (credit_out.credits !== 8'h00 || credit_available !== 1'b0 || credit_low !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL disable got=%h/%b/%b/%0d exp=00/0/0/0", credit_out.credits, credit_available, credit_low, state_dbg);
    end
    drive(1'b1, 1'b0, 9'h000);
    tick();
    checks++;
    if (credit_error !== 2'b01 || credit_out.credits !== 8'h00) begin
      failures++;
      $display("FAIL idle_request got=%h/%b exp=00/01", credit_out.credits, credit_error);
    end
    start_job(8'h12);
    checks++;
    if (credit_out.credits !== 8'h12 || credit_available !== 1'b1 || credit_error !== 2'b00) begin
      failures++;
      $display("FAIL restart got=%h/%b/%b exp=12/1/00", credit_out.credits, credit_available, credit_error);
    end
    drive(1'b0, 1'b1, 9'h1FF);
    tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (credit_out.credits !== 8'h00 || credit_available !== 1'b0 || credit_low !== 1'b0
        || credit_error !== 2'b00 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%b/%b/%0d exp=00/0/0/00/0", credit_out.credits,
               credit_available, credit_low, credit_error, state_dbg);
    end
    idle_inputs();
    enabled_in = 1'b0;
    rstn = 1'b1;
    tick();
    checks++;
    if (credit_out.credits !== 8'h00 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL post_reset got=%h/%0d exp=00/0", credit_out.credits, state_dbg);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_basic();
    test_clamp();
    test_back_to_back();
    test_underflow();
    test_overflow();
    test_disable_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
